led_shift: RTL
==============

# led_shift

LED pattern controller directly downstream of the period counter/comparator stage. It consumes that stage's one-cycle `o_valid` tick, which arrives here as `i_valid`, to advance an LED pattern. A small mode FSM selects between shift-left, shift-right and flash. Three asynchronous push-buttons drive the FSM through an internal synchronizer and rising-edge detector.

## Interface
- `NB_LEDS`, default 4: width of the LED pattern; minimum 2.
- `NB_BTN`, default 3: number of mode buttons; fixed function per bit.
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_valid`, in, 1: one-cycle advance tick from the counter/compare stage.
- `i_enable`, in, 1: when low, ticks are ignored and the pattern freezes. Mode changes are still accepted.
- `i_btn`, in, `NB_BTN`: asynchronous buttons. Bit [0] requests shift-left, [1] shift-right, [2] flash.
- `o_led`, out, `NB_LEDS`: registered LED pattern.
- `o_mode`, out, 2: registered current mode. 2'b00 LEFT, 2'b01 RIGHT, 2'b10 FLASH; 2'b11 unused.

## Operation
- Reset values:
  - `o_mode` = LEFT.
  - `o_led` = 1, i.e. bit 0 set.
  - Synchronizer and edge-detector flops = 0.
- Button path: each `i_btn` bit passes through a 2-flop synchronizer, then a rising-edge detector. The result is a one-cycle `btn_rise` per bit. A held button yields exactly one request.
- Mode FSM transitions on `btn_rise`:
  - Any state goes to LEFT on [0], RIGHT on [1], FLASH on [2].
  - Priority when several rise in the same cycle: FLASH > RIGHT > LEFT.
  - A request for the current mode is a no-op; the pattern is not reloaded.
- Pattern load on a mode change:
  - LEFT↔RIGHT keeps the current single-hot position.
  - FLASH→LEFT loads bit 0.
  - FLASH→RIGHT loads bit `NB_LEDS-1`.
  - Any→FLASH loads all ones.
- Advance happens only when `i_valid && i_enable`, and only in a cycle without a mode change:
  - LEFT: rotate left; bit `NB_LEDS-1` wraps to bit 0.
  - RIGHT: rotate right; bit 0 wraps to bit `NB_LEDS-1`.
  - FLASH: bitwise invert the whole pattern (all ones ↔ all zeros).
- Simultaneous events:
  - A mode change and a tick in the same cycle: the mode change wins and the tick is dropped.
  - A tick with `i_enable` low is discarded, not queued.
- Reset mid-operation: `i_reset` overrides everything in the same cycle. The next state equals the reset values regardless of `i_valid` or `btn_rise`.
- Invariant: in LEFT/RIGHT, `o_led` is always single-hot.

## Timing
- Tick latency: `i_valid` sampled high at edge k gives the updated `o_led` after edge k. One registered stage; no combinational input→output path.
- Button latency: `i_btn` first sampled high at edge k gives `o_mode`/`o_led` updated after edge k+3 (two synchronizer stages plus one edge/FSM stage).
- Throughput: accepts a tick every cycle, including back-to-back `i_valid`.
- Buttons must stay stable high or low for at least 3 cycles to be seen. Debounce is outside this block.

## Configuration
- Macro: `LED_SHIFT_BOUNCE_EN`.
- Defined (ping-pong behaviour):
  - In LEFT with bit `NB_LEDS-1` set, a tick switches the mode to RIGHT and the pattern to bit `NB_LEDS-2`.
  - In RIGHT with bit 0 set, a tick switches the mode to LEFT and the pattern to bit 1.
  - `o_mode` reflects the reversal in the same update.
- Undefined: rotate with wrap-around as in Operation; the mode never changes without a button.

## Structure
- Shared package `led_shift_pkg` holds:
  - Mode encodings `MODE_LEFT`, `MODE_RIGHT`, `MODE_FLASH`.
  - `MODE_W` = 2.
  - Button index constants `BTN_LEFT` = 0, `BTN_RIGHT` = 1, `BTN_FLASH` = 2.
- Sub-module `btn_edge_sync`, parameterized by width: per-bit 2-flop synchronizer plus rising-edge detector. It has the same `clock`/`i_reset` and outputs the one-cycle `btn_rise` vector.
- Top level holds the mode FSM and the pattern register.

## Test plan
- Reset, then 5 ticks with `i_enable`=1 in LEFT (`NB_LEDS`=4): `o_led` goes 0001→0010→0100→1000→0001→0010.
- Press [1] held 10 cycles while at 0100: `o_mode`=01 exactly 3 cycles after the press, `o_led` stays 0100; the next tick gives 0010; no second mode event while the button is held.
- Press [2], then 3 ticks: `o_led`=1111, then 0000, 1111, 0000; pressing [0] then loads 0001.
- Raise [0], [1] and [2] in the same cycle: `o_mode`=10 (FLASH). Separately, a tick coinciding with the `btn_rise` cycle leaves the pattern unadvanced.
- Ticks with `i_enable`=0 give no `o_led` change. Asserting `i_reset` during back-to-back ticks in FLASH gives `o_led`=0001 and `o_mode`=00 on the next cycle.
- With `LED_SHIFT_BOUNCE_EN`, 4 ticks from reset: 0001→0010→0100→1000→0100 with `o_mode`=01 at the last step. Without the macro the last step is 0001 with `o_mode`=00.

Source files
------------

// File: rtl/led_shift_pkg.sv
// rtl/led_shift_pkg.sv - shared mode encodings and button indices for led_shift
//
// Purpose: constants shared by the LED pattern controller and its testbench.
//   MODE_W                          : width of the mode encoding
//   mode_e                          : MODE_LEFT / MODE_RIGHT / MODE_FLASH (2'b11 unused)
//   BTN_LEFT / BTN_RIGHT / BTN_FLASH: bit index of each mode button in i_btn
package led_shift_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_LEFT  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_FLASH = 2'b10
  } mode_e;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_FLASH = 2;

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - per-bit 2-flop synchronizer plus registered rising-edge detector
//
// Purpose: bring asynchronous push-buttons into the clock domain and turn each
// low-to-high transition into a single-cycle pulse.
// Ports:
//   clock   in            : single clock
//   i_reset in            : synchronous, active-high reset
//   i_btn   in  [WIDTH-1:0]: asynchronous button levels
//   o_rise  out [WIDTH-1:0]: one-cycle pulse per bit on each rising edge
module btn_edge_sync #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_btn,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_q;

  // The rise pulse is registered so the FSM sees it three edges after the
  // button is first sampled, and so the FSM input comes straight from a flop.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      rise_q  <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign o_rise = rise_q;

endmodule

// File: rtl/led_shift.sv
// rtl/led_shift.sv - LED pattern controller with shift-left / shift-right / flash modes
//
// Purpose: advance an LED pattern on each enabled tick from the period
// counter/compare stage; three push-buttons select the mode.
// Ports:
//   clock    in               : single clock
//   i_reset  in               : synchronous, active-high reset
//   i_valid  in               : one-cycle advance tick
//   i_enable in               : when low, ticks are discarded
//   i_btn    in  [NB_BTN-1:0] : asynchronous buttons ([0] left, [1] right, [2] flash)
//   o_led    out [NB_LEDS-1:0]: registered LED pattern
//   o_mode   out [1:0]        : registered mode (00 left, 01 right, 10 flash)
// Build option: LED_SHIFT_BOUNCE_EN - when defined, a single-hot pattern that
// reaches the end bit reverses direction instead of wrapping.
module led_shift
  import led_shift_pkg::*;
#(
  parameter int NB_LEDS = 4,
  parameter int NB_BTN  = 3
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [NB_BTN-1:0]  i_btn,
  output logic [NB_LEDS-1:0] o_led,
  output logic [MODE_W-1:0]  o_mode
);

  localparam logic [NB_LEDS-1:0] LED_LSB = NB_LEDS'(1);
  localparam logic [NB_LEDS-1:0] LED_MSB = LED_LSB << (NB_LEDS - 1);

  logic [NB_BTN-1:0]  btn_rise;
  mode_e              mode_q, mode_d;
  logic [NB_LEDS-1:0] led_q, led_d;
  logic               req_vld;
  mode_e              req_mode;

  btn_edge_sync #(
    .WIDTH (NB_BTN)
  ) u_btn_edge_sync (
    .clock   (clock),
    .i_reset (i_reset),
    .i_btn   (i_btn),
    .o_rise  (btn_rise)
  );

  // State register
  always_ff @(posedge clock) begin
    if (i_reset) begin
      mode_q <= MODE_LEFT;
      led_q  <= LED_LSB;
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
    end
  end

  // Next-state logic
  always_comb begin
    mode_d   = mode_q;
    led_d    = led_q;
    req_vld  = btn_rise[BTN_FLASH] | btn_rise[BTN_RIGHT] | btn_rise[BTN_LEFT];
    req_mode = MODE_LEFT;
    if (btn_rise[BTN_FLASH]) begin
      req_mode = MODE_FLASH;
    end else if (btn_rise[BTN_RIGHT]) begin
      req_mode = MODE_RIGHT;
    end

    if (req_vld && (req_mode != mode_q)) begin
      // Mode change wins over a coincident tick; the tick is dropped.
      mode_d = req_mode;
      case (req_mode)
        MODE_FLASH: led_d = '1;
        MODE_LEFT:  led_d = (mode_q == MODE_FLASH) ? LED_LSB : led_q;
        MODE_RIGHT: led_d = (mode_q == MODE_FLASH) ? LED_MSB : led_q;
        default:    led_d = LED_LSB;
      endcase
    end else if (i_valid && i_enable) begin
      case (mode_q)
        MODE_LEFT: begin
`ifdef LED_SHIFT_BOUNCE_EN
          if (led_q[NB_LEDS-1]) begin
            mode_d = MODE_RIGHT;
            led_d  = LED_MSB >> 1;
          end else begin
            led_d  = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
          end
`else
          led_d = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
`endif
        end
        MODE_RIGHT: begin
`ifdef LED_SHIFT_BOUNCE_EN
          if (led_q[0]) begin
            mode_d = MODE_LEFT;
            led_d  = LED_LSB << 1;
          end else begin
            led_d  = {led_q[0], led_q[NB_LEDS-1:1]};
          end
`else
          led_d = {led_q[0], led_q[NB_LEDS-1:1]};
`endif
        end
        MODE_FLASH: led_d = ~led_q;
        default: begin
          // Unused encoding: recover to the reset state.
          mode_d = MODE_LEFT;
          led_d  = LED_LSB;
        end
      endcase
    end
  end

  // Outputs come straight from the state register.
  always_comb begin
    o_mode = mode_q;
    o_led  = led_q;
  end

endmodule
